// File: rtl/decoder_2x4_hs.sv
// 2-to-4 one-hot decoder behind a valid/ready handshake with a 2-entry skid buffer.
// Invalid (V=0) codes are counted and either dropped or forwarded as all-zero words.
module decoder_2x4_hs #(
  parameter int CNT_W        = 8,
  parameter bit DROP_INVALID = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       Y,
  input  logic             V,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       D,
  output logic             DV,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] inv_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [3:0] d;
    logic       dv;
  } word_t;

  state_t          state, state_nxt;
  word_t [1:0]     mem;
  word_t           in_word;
  logic            wr_ptr, rd_ptr;
  logic            push, pop, push_buf;

  assign in_word.d  = V ? (4'b0001 << Y) : 4'b0000;
  assign in_word.dv = V;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  // Dropped invalid codes still complete the handshake but never occupy an entry.
  assign push_buf = push & (V | !DROP_INVALID);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push_buf) state_nxt = ONE;
      ONE: begin
        if (push_buf && !pop)      state_nxt = FULL;
        else if (pop && !push_buf) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      mem       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      inv_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (push_buf) begin
        mem[wr_ptr] <= in_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Handshake flags are registered from next state so in_ready has no path from out_ready.
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      if (clr_cnt)                       inv_cnt <= '0;
      else if (push && !V && inv_cnt != '1) inv_cnt <= inv_cnt + 1'b1;
    end
  end

  assign D  = out_valid ? mem[rd_ptr].d  : 4'b0000;
  assign DV = out_valid ? mem[rd_ptr].dv : 1'b0;

endmodule

// File: tb/tb_decoder_2x4_hs.sv
// Scoreboard bench: u0 drops invalid codes (CNT_W=8), u1 forwards them (CNT_W=2); shared stimulus.
module tb_decoder_2x4_hs;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, V, out_ready, clr_cnt;
  logic [1:0] Y;
  logic       in_ready0, out_valid0, dv0, in_ready1, out_valid1, dv1;
  logic [3:0] d0, d1;
  logic [7:0] inv_cnt0;
  logic [1:0] inv_cnt1;

  typedef struct {
    logic [4:0] w;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  bit   lat_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decoder_2x4_hs #(.CNT_W(8), .DROP_INVALID(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .Y(Y), .V(V),
    .out_valid(out_valid0), .out_ready(out_ready), .D(d0), .DV(dv0),
    .clr_cnt(clr_cnt), .inv_cnt(inv_cnt0));

  decoder_2x4_hs #(.CNT_W(2), .DROP_INVALID(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .Y(Y), .V(V),
    .out_valid(out_valid1), .out_ready(out_ready), .D(d1), .DV(dv1),
    .clr_cnt(clr_cnt), .inv_cnt(inv_cnt1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the edge that accepted the code.
  task automatic send(input logic v, input logic [1:0] y, input logic [4:0] expw);
    exp_t e;
    int   t = 0;
    in_valid = 1'b1;
    V        = v;
    Y        = y;
    while (!in_ready0 && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) begin
      chk("in_ready timeout", 32'(in_ready0), 32'd1);
    end else begin
      e.w   = expw;
      e.cyc = cyc + 1;
      e.lat = lat_mode;
      if (v) q0.push_back(e);
      q1.push_back(e);
      tick();
    end
  endtask

  // Each cycle a word is presented it must match the scoreboard head; stalled cycles recheck the same head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL u0 unexpected word: got %0h expected none (cycle %0d)", {d0, dv0}, cyc);
        end else begin
          chk("u0 word", 32'({d0, dv0}), 32'(q0[0].w));
          if (out_ready) begin
            if (q0[0].lat) chk("u0 latency", cyc, q0[0].cyc);
            void'(q0.pop_front());
          end
        end
      end
      if (out_valid1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL u1 unexpected word: got %0h expected none (cycle %0d)", {d1, dv1}, cyc);
        end else begin
          chk("u1 word", 32'({d1, dv1}), 32'(q1[0].w));
          if (out_ready) begin
            if (q1[0].lat) chk("u1 latency", cyc, q1[0].cyc);
            void'(q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with live stimulus
    rst_n = 1'b0; in_valid = 1'b1; V = 1'b1; Y = 2'd2; out_ready = 1'b1; clr_cnt = 1'b0;
    tick(); tick();
    chk("rst out_valid", 32'(out_valid0), 32'd0);
    chk("rst inv_cnt", 32'(inv_cnt0), 32'd0);
    chk("rst D", 32'({d0, dv0}), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post-rst in_ready", 32'(in_ready0), 32'd1);
    chk("post-rst out_valid", 32'(out_valid0), 32'd0);

    // 2: back-to-back stream, one-cycle latency, no bubbles
    lat_mode = 1'b1;
    send(1'b1, 2'd0, 5'b0001_1);
    send(1'b1, 2'd1, 5'b0010_1);
    send(1'b1, 2'd2, 5'b0100_1);
    send(1'b1, 2'd3, 5'b1000_1);
    in_valid = 1'b0;
    lat_mode = 1'b0;
    repeat (3) tick();

    // 3: stall, buffer fills, third code held off
    out_ready = 1'b0;
    send(1'b1, 2'd2, 5'b0100_1);
    send(1'b1, 2'd1, 5'b0010_1);
    chk("full in_ready", 32'(in_ready0), 32'd0);
    fork
      begin
        send(1'b1, 2'd3, 5'b1000_1);
        in_valid = 1'b0;
      end
      begin
        repeat (3) tick();
        chk("stalled in_ready", 32'(in_ready0), 32'd0);
        chk("stalled out_valid", 32'(out_valid0), 32'd1);
        out_ready = 1'b1;
      end
    join
    repeat (3) tick();

    // 4: invalid codes: u0 drops, u1 forwards zero words
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    send(1'b0, 2'd0, 5'b0000_0);
    send(1'b0, 2'd3, 5'b0000_0);
    send(1'b0, 2'd1, 5'b0000_0);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("u0 inv_cnt 3", 32'(inv_cnt0), 32'd3);
    chk("u1 inv_cnt 3", 32'(inv_cnt1), 32'd3);
    chk("u0 idle out_valid", 32'(out_valid0), 32'd0);

    // 5: saturation on the 2-bit counter, clear beats increment
    send(1'b0, 2'd2, 5'b0000_0);
    send(1'b0, 2'd2, 5'b0000_0);
    in_valid = 1'b0;
    tick();
    chk("u1 inv_cnt sat", 32'(inv_cnt1), 32'd3);
    chk("u0 inv_cnt 5", 32'(inv_cnt0), 32'd5);
    clr_cnt = 1'b1;
    send(1'b0, 2'd1, 5'b0000_0);
    clr_cnt = 1'b0; in_valid = 1'b0;
    chk("u0 clr wins", 32'(inv_cnt0), 32'd0);
    chk("u1 clr wins", 32'(inv_cnt1), 32'd0);
    repeat (2) tick();

    // 6: reset while FULL discards both entries
    out_ready = 1'b0;
    send(1'b1, 2'd3, 5'b1000_1);
    send(1'b1, 2'd0, 5'b0001_1);
    in_valid = 1'b0;
    chk("pre-rst full", 32'(in_ready0), 32'd0);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    tick();
    chk("mid-rst out_valid u0", 32'(out_valid0), 32'd0);
    chk("mid-rst in_ready u0", 32'(in_ready0), 32'd1);
    chk("mid-rst out_valid u1", 32'(out_valid1), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    chk("u0 words outstanding", q0.size(), 32'd0);
    chk("u1 words outstanding", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
